// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX operand forwarding and load-use hazard detection.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_e,
    input  logic        flush_e,
    input  logic [31:0] rd1_d,
    input  logic [31:0] rd2_d,
    input  logic [31:0] pc_d,
    input  logic [31:0] immext_d,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [4:0]  rd_d,
    input  logic [2:0]  alucontrol_d,
    input  logic        alusrc_d,
    input  logic        regwrite_d,
    input  logic        memwrite_d,
    input  logic        branch_d,
    input  logic        jump_d,
    input  logic        valid_d,
    input  logic [1:0]  resultsrc_d,
    input  logic [31:0] aluresult_m,
    input  logic [4:0]  rd_m,
    input  logic        regwrite_m,
    input  logic [31:0] result_w,
    input  logic [4:0]  rd_w,
    input  logic        regwrite_w,
    output logic [31:0] srca_e,
    output logic [31:0] srcb_e,
    output logic [2:0]  alucontrol_e,
    output logic [31:0] writedata_e,
    output logic [31:0] pc_e,
    output logic [31:0] immext_e,
    output logic [4:0]  rs1_e,
    output logic [4:0]  rs2_e,
    output logic [4:0]  rd_e,
    output logic        regwrite_e,
    output logic        memwrite_e,
    output logic        branch_e,
    output logic        jump_e,
    output logic        valid_e,
    output logic [1:0]  resultsrc_e,
    output logic [1:0]  forwarda_e,
    output logic [1:0]  forwardb_e,
    output logic        loaduse_stall
);
    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] immext;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  alucontrol;
        logic        alusrc;
        logic        regwrite;
        logic        memwrite;
        logic        branch;
        logic        jump;
        logic        valid;
        logic [1:0]  resultsrc;
    } stage_t;

    stage_t d, q;

    assign d = '{rd1: rd1_d, rd2: rd2_d, pc: pc_d, immext: immext_d,
                 rs1: rs1_d, rs2: rs2_d, rd: rd_d, alucontrol: alucontrol_d,
                 alusrc: alusrc_d, regwrite: regwrite_d, memwrite: memwrite_d,
                 branch: branch_d, jump: jump_d, valid: valid_d, resultsrc: resultsrc_d};

    // A bubble is an all-zero stage, so flush simply clears like reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (flush_e)
            q <= '0;
        else if (!stall_e)
            q <= d;
    end

    assign pc_e         = q.pc;
    assign immext_e     = q.immext;
    assign rs1_e        = q.rs1;
    assign rs2_e        = q.rs2;
    assign rd_e         = q.rd;
    assign alucontrol_e = q.alucontrol;
    assign regwrite_e   = q.regwrite;
    assign memwrite_e   = q.memwrite;
    assign branch_e     = q.branch;
    assign jump_e       = q.jump;
    assign valid_e      = q.valid;
    assign resultsrc_e  = q.resultsrc;

    // MEM result is younger than WB, so it wins when both target the same register.
    assign forwarda_e = (regwrite_m && rd_m != 5'd0 && rd_m == q.rs1) ? 2'b10 :
                        (regwrite_w && rd_w != 5'd0 && rd_w == q.rs1) ? 2'b01 : 2'b00;
    assign forwardb_e = (regwrite_m && rd_m != 5'd0 && rd_m == q.rs2) ? 2'b10 :
                        (regwrite_w && rd_w != 5'd0 && rd_w == q.rs2) ? 2'b01 : 2'b00;

    assign srca_e      = forwarda_e == 2'b10 ? aluresult_m : forwarda_e == 2'b01 ? result_w : q.rd1;
    assign writedata_e = forwardb_e == 2'b10 ? aluresult_m : forwardb_e == 2'b01 ? result_w : q.rd2;
    assign srcb_e      = q.alusrc ? q.immext : writedata_e;

    assign loaduse_stall = q.resultsrc == 2'b01 && q.regwrite && q.rd != 5'd0 &&
                           (q.rd == rs1_d || q.rd == rs2_d);
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table, corner-case sequences and randomized run against a behavioural model.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        reset, stall_e, flush_e;
    logic [31:0] rd1_d, rd2_d, pc_d, immext_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [2:0]  alucontrol_d;
    logic        alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d, valid_d;
    logic [1:0]  resultsrc_d;
    logic [31:0] aluresult_m, result_w;
    logic [4:0]  rd_m, rd_w;
    logic        regwrite_m, regwrite_w;
    logic [31:0] srca_e, srcb_e, writedata_e, pc_e, immext_e;
    logic [2:0]  alucontrol_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        regwrite_e, memwrite_e, branch_e, jump_e, valid_e;
    logic [1:0]  resultsrc_e, forwarda_e, forwardb_e;
    logic        loaduse_stall;

    int checks = 0;
    int failures = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d), .immext_d(immext_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .alucontrol_d(alucontrol_d),
        .alusrc_d(alusrc_d), .regwrite_d(regwrite_d), .memwrite_d(memwrite_d),
        .branch_d(branch_d), .jump_d(jump_d), .valid_d(valid_d), .resultsrc_d(resultsrc_d),
        .aluresult_m(aluresult_m), .rd_m(rd_m), .regwrite_m(regwrite_m),
        .result_w(result_w), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .srca_e(srca_e), .srcb_e(srcb_e), .alucontrol_e(alucontrol_e), .writedata_e(writedata_e),
        .pc_e(pc_e), .immext_e(immext_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .branch_e(branch_e),
        .jump_e(jump_e), .valid_e(valid_e), .resultsrc_e(resultsrc_e),
        .forwarda_e(forwarda_e), .forwardb_e(forwardb_e), .loaduse_stall(loaduse_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1, rd2, pc, immext;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  alucontrol;
        logic        alusrc, regwrite, memwrite, branch, jump, valid;
        logic [1:0]  resultsrc;
    } ex_t;

    ex_t m;
    ex_t snap;

    typedef struct {
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        alusrc;
        logic [1:0]  rsrc;
        logic        rw;
        logic [2:0]  alu;
        logic        stall, flush;
        logic [31:0] am;
        logic [4:0]  rdm;
        logic        rwm;
        logic [31:0] wr;
        logic [4:0]  rdw;
        logic        rww;
        logic [4:0]  p1, p2;
        logic [31:0] srca, srcb, wd;
        logic [1:0]  fa, fb;
        logic        lus;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Forwarding choice from the hazard rules: newest producer first, never x0.
    function automatic logic [1:0] fsel(input logic [4:0] rs);
        if (regwrite_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (regwrite_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] fval(input logic [4:0] rs, input logic [31:0] r);
        logic [1:0] s;
        s = fsel(rs);
        if (s == 2'b10) return aluresult_m;
        if (s == 2'b01) return result_w;
        return r;
    endfunction

    task automatic check_all();
        logic [31:0] wd;
        logic        lu;
        wd = fval(m.rs2, m.rd2);
        lu = m.resultsrc == 2'b01 && m.regwrite && m.rd != 0 && (m.rd == rs1_d || m.rd == rs2_d);
        chk("forwarda", 32'(forwarda_e), 32'(fsel(m.rs1)));
        chk("forwardb", 32'(forwardb_e), 32'(fsel(m.rs2)));
        chk("srca", srca_e, fval(m.rs1, m.rd1));
        chk("writedata", writedata_e, wd);
        chk("srcb", srcb_e, m.alusrc ? m.immext : wd);
        chk("alucontrol", 32'(alucontrol_e), 32'(m.alucontrol));
        chk("pc", pc_e, m.pc);
        chk("immext", immext_e, m.immext);
        chk("rs1", 32'(rs1_e), 32'(m.rs1));
        chk("rs2", 32'(rs2_e), 32'(m.rs2));
        chk("rd", 32'(rd_e), 32'(m.rd));
        chk("regwrite", 32'(regwrite_e), 32'(m.regwrite));
        chk("memwrite", 32'(memwrite_e), 32'(m.memwrite));
        chk("branch", 32'(branch_e), 32'(m.branch));
        chk("jump", 32'(jump_e), 32'(m.jump));
        chk("valid", 32'(valid_e), 32'(m.valid));
        chk("resultsrc", 32'(resultsrc_e), 32'(m.resultsrc));
        chk("loaduse", 32'(loaduse_stall), 32'(lu));
    endtask

    // Advance one edge, applying reset > flush > stall > load to the model.
    task automatic tick();
        @(posedge clk);
        if (reset || flush_e)
            m = '{default: 0};
        else if (!stall_e)
            m = '{rd1: rd1_d, rd2: rd2_d, pc: pc_d, immext: immext_d, rs1: rs1_d, rs2: rs2_d,
                  rd: rd_d, alucontrol: alucontrol_d, alusrc: alusrc_d, regwrite: regwrite_d,
                  memwrite: memwrite_d, branch: branch_d, jump: jump_d, valid: valid_d,
                  resultsrc: resultsrc_d};
        #1;
    endtask

    task automatic rand_d();
        rd1_d = $urandom; rd2_d = $urandom; pc_d = $urandom; immext_d = $urandom;
        rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7)); rd_d = 5'($urandom_range(0, 7));
        alucontrol_d = 3'($urandom); alusrc_d = 1'($urandom); regwrite_d = 1'($urandom);
        memwrite_d = 1'($urandom); branch_d = 1'($urandom); jump_d = 1'($urandom);
        valid_d = 1'($urandom); resultsrc_d = 2'($urandom_range(0, 2));
    endtask

    task automatic rand_fwd();
        aluresult_m = $urandom; rd_m = 5'($urandom_range(0, 7)); regwrite_m = 1'($urandom);
        result_w = $urandom; rd_w = 5'($urandom_range(0, 7)); regwrite_w = 1'($urandom);
    endtask

    initial begin
        //         rd1    rd2    imm   rs1 rs2 rd as rsrc rw alu st fl  am     rdm rwm wr     rdw rww p1 p2 srca   srcb   wd     fa fb lus
        tbl[0] = '{5,     7,     0,    1,  2,  3, 0, 0,   1, 0, 0, 0, 0,     0,  0,  0,     0,  0,  0, 0, 5,     7,     7,     0, 0, 0};
        tbl[1] = '{'h100, 'h200, 'h44, 3,  5,  6, 1, 0,   1, 7, 0, 0, 'h10,  3,  1,  'h20,  3,  1,  0, 0, 'h10,  'h44,  'h200, 2, 0, 0};
        tbl[2] = '{1,     2,     0,    7,  8,  9, 0, 0,   1, 2, 0, 0, 'h11,  8,  1,  'h22,  7,  1,  0, 0, 'h22,  'h11,  'h11,  1, 2, 0};
        tbl[3] = '{9,     'hAB,  0,    0,  0,  1, 0, 0,   1, 0, 0, 0, 'hFF,  0,  1,  'hEE,  0,  1,  0, 0, 9,     'hAB,  'hAB,  0, 0, 0};
        tbl[4] = '{3,     4,     0,    4,  0,  2, 0, 0,   1, 1, 0, 0, 'h77,  4,  0,  'h33,  4,  1,  0, 0, 'h33,  4,     4,     1, 0, 0};
        tbl[5] = '{'h50,  'h60,  8,    1,  2,  4, 0, 1,   1, 0, 0, 0, 0,     0,  0,  0,     0,  0,  0, 4, 'h50,  'h60,  'h60,  0, 0, 1};
        tbl[6] = '{'h50,  'h60,  8,    1,  2,  4, 0, 1,   1, 0, 0, 1, 'h99,  0,  1,  0,     0,  0,  0, 4, 0,     0,     0,     0, 0, 0};
        tbl[7] = '{1,     2,     0,    1,  2,  0, 0, 1,   1, 0, 0, 0, 0,     0,  0,  0,     0,  0,  0, 0, 1,     2,     2,     0, 0, 0};
        tbl[8] = '{1,     2,     0,    1,  2,  5, 0, 1,   0, 0, 0, 0, 0,     0,  0,  0,     0,  0,  5, 0, 1,     2,     2,     0, 0, 0};
        tbl[9] = '{1,     2,     0,    1,  2,  5, 0, 1,   1, 0, 0, 0, 0,     0,  0,  0,     0,  0,  5, 0, 1,     2,     2,     0, 0, 1};

        m = '{default: 0};
        reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
        rand_d();
        aluresult_m = 0; rd_m = 0; regwrite_m = 0; result_w = 0; rd_w = 0; regwrite_w = 0;
        tick();
        tick();
        check_all();
        chk("reset_valid", 32'(valid_e), 0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd1_d = tbl[i].rd1; rd2_d = tbl[i].rd2; immext_d = tbl[i].imm; pc_d = 32'(i * 4);
            rs1_d = tbl[i].rs1; rs2_d = tbl[i].rs2; rd_d = tbl[i].rd; alusrc_d = tbl[i].alusrc;
            resultsrc_d = tbl[i].rsrc; regwrite_d = tbl[i].rw; alucontrol_d = tbl[i].alu;
            memwrite_d = 1'b0; branch_d = 1'b0; jump_d = 1'b0; valid_d = 1'b1;
            stall_e = tbl[i].stall; flush_e = tbl[i].flush;
            tick();
            aluresult_m = tbl[i].am; rd_m = tbl[i].rdm; regwrite_m = tbl[i].rwm;
            result_w = tbl[i].wr; rd_w = tbl[i].rdw; regwrite_w = tbl[i].rww;
            rs1_d = tbl[i].p1; rs2_d = tbl[i].p2;
            #1;
            chk($sformatf("vec%0d_srca", i), srca_e, tbl[i].srca);
            chk($sformatf("vec%0d_srcb", i), srcb_e, tbl[i].srcb);
            chk($sformatf("vec%0d_writedata", i), writedata_e, tbl[i].wd);
            chk($sformatf("vec%0d_forwarda", i), 32'(forwarda_e), 32'(tbl[i].fa));
            chk($sformatf("vec%0d_forwardb", i), 32'(forwardb_e), 32'(tbl[i].fb));
            chk($sformatf("vec%0d_loaduse", i), 32'(loaduse_stall), 32'(tbl[i].lus));
            chk($sformatf("vec%0d_alucontrol", i), 32'(alucontrol_e), tbl[i].flush ? 0 : 32'(tbl[i].alu));
            check_all();
        end

        // Stall holds for three cycles with changing decode inputs, then stall+flush gives a bubble.
        @(negedge clk);
        rand_d(); valid_d = 1'b1; rd_d = 5'd6; stall_e = 1'b0; flush_e = 1'b0;
        tick();
        snap = m;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rand_d(); stall_e = 1'b1;
            tick();
            check_all();
            chk("stall_pc", pc_e, snap.pc);
            chk("stall_rd", 32'(rd_e), 6);
        end
        @(negedge clk);
        rand_d(); stall_e = 1'b1; flush_e = 1'b1;
        tick();
        check_all();
        chk("stallflush_valid", 32'(valid_e), 0);
        chk("stallflush_rd", 32'(rd_e), 0);

        // Reset asserted mid-cycle clears outputs before the next edge.
        @(negedge clk);
        rand_d(); valid_d = 1'b1; regwrite_d = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
        tick();
        chk("pre_reset_valid", 32'(valid_e), 1);
        chk("pre_reset_regwrite", 32'(regwrite_e), 1);
        #1;
        reset = 1'b1;
        m = '{default: 0};
        #1;
        check_all();
        chk("async_reset_valid", 32'(valid_e), 0);
        chk("async_reset_regwrite", 32'(regwrite_e), 0);
        @(negedge clk);
        reset = 1'b0;
        rand_d(); valid_d = 1'b1;
        tick();
        check_all();
        chk("resume_valid", 32'(valid_e), 1);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rand_d();
            rand_fwd();
            stall_e = ($urandom_range(0, 3) == 0);
            flush_e = ($urandom_range(0, 7) == 0);
            tick();
            check_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
